// File: rtl/lif_pkg.sv
// Shared types and defaults for the time-multiplexed LIF neuron scheduler.
// Holds the default datapath widths, the sweep FSM state encoding and the
// saturating adder used by the single-neuron update datapath.
package lif_pkg;

    localparam int W_DEF          = 8;
    localparam int LEAK_SHIFT_DEF = 2;
    localparam int REFRAC_DEF     = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Unsigned add clamped to max_val. Operands are at most 32 bits wide, so
    // the 33-bit sum can never wrap before the clamp is applied.
    function automatic logic [32:0] sat_add(input logic [32:0] a,
                                            input logic [32:0] b,
                                            input logic [32:0] max_val);
        logic [32:0] s;
        s = a + b;
        return (s > max_val) ? max_val : s;
    endfunction

endpackage

// File: rtl/lif_update.sv
// Purpose: one leaky integrate-and-fire neuron update, purely combinational.
// Latency: zero cycles (result is consumed by the caller's write-back edge).
// Backpressure: none; a fresh result is produced for every operand set.
// Ports: v/ref_cnt = current membrane and refractory count, isyn = input
// current, threshold = firing level; v_next/ref_next/spike = updated state.
module lif_update
    import lif_pkg::*;
#(
    parameter int W          = W_DEF,
    parameter int LEAK_SHIFT = LEAK_SHIFT_DEF,
    parameter int REFRAC     = REFRAC_DEF,
    parameter int RW         = 2
) (
    input  logic [W-1:0]  v,
    input  logic [RW-1:0] ref_cnt,
    input  logic [W-1:0]  isyn,
    input  logic [W-1:0]  threshold,
    output logic [W-1:0]  v_next,
    output logic [RW-1:0] ref_next,
    output logic          spike
);

    logic [W-1:0] leaked;
    logic [W-1:0] sum;

    always_comb begin
        // v - (v >> LEAK_SHIFT) never underflows, so W bits are enough here.
        leaked = v - (v >> LEAK_SHIFT);
        sum    = W'(sat_add(33'(leaked), 33'(isyn),
                            {{(33-W){1'b0}}, {W{1'b1}}}));

        v_next   = sum;
        ref_next = '0;
        spike    = 1'b0;
        if (ref_cnt != '0) begin
            // Refractory: membrane is clamped and the input current ignored.
            v_next   = '0;
            ref_next = ref_cnt - RW'(1);
        end else if (sum >= threshold) begin
            v_next   = '0;
            ref_next = RW'(REFRAC);
            spike    = 1'b1;
        end
    end

endmodule

// File: rtl/lif_scheduler.sv
// Purpose: sweeps NUM_NEURONS LIF neurons through one shared update datapath
// per timestep tick; latency N+2 cycles from tick accept to done/spikes.
// Backpressure: ticks arriving mid-sweep are dropped and flagged on overrun.
// Ports: clk/rst (sync, active high); tick + ext_current/weight/threshold are
// sampled on accept; busy, done (pulse), spikes (last timestep), overrun (pulse).
module lif_scheduler
    import lif_pkg::*;
#(
    parameter int NUM_NEURONS = 4,
    parameter int W           = W_DEF,
    parameter int LEAK_SHIFT  = LEAK_SHIFT_DEF,
    parameter int REFRAC      = REFRAC_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic [W-1:0]           ext_current,
    input  logic [W-1:0]           weight,
    input  logic [W-1:0]           threshold,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_NEURONS-1:0] spikes,
    output logic                   overrun
);

    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam int IW = $clog2(NUM_NEURONS);

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [W-1:0]           v_q [NUM_NEURONS];
    logic [W-1:0]           v_d [NUM_NEURONS];
    logic [RW-1:0]          ref_q [NUM_NEURONS];
    logic [RW-1:0]          ref_d [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] spk_next_q, spk_next_d;
    logic [NUM_NEURONS-1:0] spikes_q, spikes_d;
    logic [W-1:0]           ext_q, ext_d;
    logic [W-1:0]           weight_q, weight_d;
    logic [W-1:0]           thr_q, thr_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   overrun_q, overrun_d;

    logic [W-1:0]           cur_v, cur_isyn, upd_v;
    logic [RW-1:0]          cur_ref, upd_ref;
    logic                   upd_spike;

    // Operand fetch for the neuron at idx_q. Neurons k>0 read the published
    // vector, not spk_next, so the result does not depend on sweep order.
    always_comb begin
        cur_v    = '0;
        cur_ref  = '0;
        cur_isyn = ext_q;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_v   = v_q[i];
                cur_ref = ref_q[i];
            end
        end
        for (int k = 1; k < NUM_NEURONS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_isyn = spikes_q[k-1] ? weight_q : '0;
            end
        end
    end

    lif_update #(
        .W          (W),
        .LEAK_SHIFT (LEAK_SHIFT),
        .REFRAC     (REFRAC),
        .RW         (RW)
    ) u_update (
        .v         (cur_v),
        .ref_cnt   (cur_ref),
        .isyn      (cur_isyn),
        .threshold (thr_q),
        .v_next    (upd_v),
        .ref_next  (upd_ref),
        .spike     (upd_spike)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        v_d        = v_q;
        ref_d      = ref_q;
        spk_next_d = spk_next_q;
        spikes_d   = spikes_q;
        ext_d      = ext_q;
        weight_d   = weight_q;
        thr_d      = thr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overrun_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    ext_d    = ext_current;
                    weight_d = weight;
                    thr_d    = threshold;
                    idx_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                overrun_d = tick;
                for (int i = 0; i < NUM_NEURONS; i++) begin
                    if (idx_q == IW'(i)) begin
                        v_d[i]        = upd_v;
                        ref_d[i]      = upd_ref;
                        spk_next_d[i] = upd_spike;
                    end
                end
                if (idx_q == IW'(NUM_NEURONS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_DONE: begin
                overrun_d = tick;
                spikes_d  = spk_next_q;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                v_q[i]   <= '0;
                ref_q[i] <= '0;
            end
            spk_next_q <= '0;
            spikes_q   <= '0;
            ext_q      <= '0;
            weight_q   <= '0;
            thr_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            v_q        <= v_d;
            ref_q      <= ref_d;
            spk_next_q <= spk_next_d;
            spikes_q   <= spikes_d;
            ext_q      <= ext_d;
            weight_q   <= weight_d;
            thr_q      <= thr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign spikes  = spikes_q;
    assign overrun = overrun_q;

endmodule

// File: doc/lif_scheduler.md
Name: lif_scheduler

Overview:
- Time-multiplexed controller that shares one LIF update datapath across NUM_NEURONS neurons.
- Membrane potentials and refractory counters are held in a register file.
- On each timestep `tick`, an FSM walks the neurons in index order and runs one update per neuron per cycle, then publishes the new spike vector.
- Neuron 0 is driven by an external current; neuron k>0 is driven by neuron k-1's spike from the previous timestep, scaled by a programmable weight. This forms a feed-forward chain.

Parameters:
- NUM_NEURONS, 4, number of neurons sequenced (2..16).
- W, 8, membrane/current/threshold width in bits.
- LEAK_SHIFT, 2, leak term is v >> LEAK_SHIFT.
- REFRAC, 2, refractory length in timesteps after a spike (0 = none).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- tick  input  1  start-of-timestep pulse.
- ext_current  input  W  synaptic current for neuron 0, sampled on tick accept.
- weight  input  W  chain synaptic weight, sampled on tick accept.
- threshold  input  W  firing threshold, sampled on tick accept.
- busy  output  1  high while a timestep sweep is in progress.
- done  output  1  one-cycle pulse at sweep end.
- spikes  output  NUM_NEURONS  spike vector of the last completed timestep.
- overrun  output  1  one-cycle pulse when a tick arrives while busy.

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset state:
  - FSM in IDLE; all v[i]=0; all ref[i]=0.
  - spikes=0, busy=0, done=0, overrun=0.
  - Latched ext/weight/threshold=0.
  - rst mid-sweep aborts the sweep; spikes is not updated.
- FSM states: IDLE, CALC, DONE.
  - IDLE: on tick, latch ext_current, weight and threshold, set idx=0, go to CALC. busy=1 from the next cycle.
  - CALC: one neuron per cycle at index idx, with its write-back on the same edge. Results accumulate in the internal vector spk_next[idx]. Increment idx; after idx=NUM_NEURONS-1, go to DONE.
  - DONE: spikes <= spk_next, done=1 for this one cycle, busy=0, return to IDLE.
- Latency:
  - A tick accepted at edge E0 gives CALC cycles E1..E(N).
  - done and the new spikes are visible in the cycle after edge E(N+1).
  - A tick is accepted again in that same cycle (IDLE), so back-to-back period is N+2 cycles.
- Tick while busy (CALC or DONE): ignored, overrun pulses one cycle, state is unaffected.
- Input current per neuron:
  - isyn(0) = latched ext_current.
  - isyn(k) = spikes[k-1] ? latched weight : 0, using the published previous-timestep vector.
  - The result is independent of sweep order.
- Update for neuron i, in unsigned arithmetic on W+1 bits:
  - If ref[i]!=0: v[i] <= 0, ref[i] <= ref[i]-1, spike=0; isyn is discarded.
  - Else: sum = v - (v>>LEAK_SHIFT) + isyn, saturated to 2^W-1.
    - If sum >= threshold: spike=1, v[i] <= 0, ref[i] <= REFRAC.
    - Else: spike=0, v[i] <= sum.
  - threshold=0 makes every non-refractory neuron spike each timestep. This is legal.
- ref[] width is clog2(REFRAC+1), minimum 1.

Decomposition:
- Shared package lif_pkg holds:
  - default W, LEAK_SHIFT, REFRAC;
  - FSM state enum (IDLE/CALC/DONE);
  - function for the saturating add.
- Sub-module lif_update: a purely combinational single-neuron datapath.
  - Inputs: v, ref, isyn, threshold.
  - Outputs: v_next, ref_next, spike.
  - lif_scheduler instantiates it once; the register file and FSM stay in lif_scheduler.

Test Plan:
1. Reset then idle:
   - Stimulus: assert rst 2 cycles, release, no tick.
   - Response: spikes=0, busy=0, done=0 indefinitely.
   - Stimulus: assert rst mid-CALC.
   - Response: returns to IDLE next cycle, spikes unchanged at 0.
2. Integrate/fire/refractory (N=4, W=8, LEAK_SHIFT=2, REFRAC=2):
   - Setup: ext=60, threshold=100, weight=0, five ticks.
   - Response: v0 = 60, then 105 → spike at step 2 (spikes=0001).
   - Steps 3 and 4: spikes=0000, v0 held at 0.
   - Step 5: v0=60.
3. Chain propagation:
   - Setup: as scenario 2 but weight=120.
   - Response: neuron 1 spikes at step 3 (spikes=0010), driven by step-2 spike of neuron 0.
   - Step 4: neuron 2 spikes (0100).
4. Saturation:
   - Setup: ext=200, threshold=255.
   - Response: step 1 v0=200, no spike. Step 2 sum 350 saturates to 255 → spike=1.
5. Timing and overrun (N=4):
   - Stimulus: tick at edge E0.
   - Response: busy high E1..E5, done pulses in cycle after E5 (N+2=6-cycle period).
   - Stimulus: extra tick at E2.
   - Response: overrun pulses once, spike results unchanged.
6. Threshold=0:
   - Response: neuron 0 spikes on every non-refractory step, i.e. steps 1, 4, 7 with REFRAC=2.
